// File: rtl/elastic_pipe_chain_if.sv
// Handshake bundle for elastic_pipe_chain.
//   master : upstream/downstream driver side (offers in_*, consumes out_*, requests flush)
//   slave  : the pipe chain itself
// Signals:
//   in_valid/in_data/in_ready     entry handshake into stage 0
//   out_valid/out_data/out_seq    exit stage contents, out_ready consumes
//   flush_req/flush_lvl           kill the youngest flush_lvl stages this cycle
//   occupancy/kill_cnt            registered status
interface elastic_pipe_chain_if #(
  parameter int DATA_W = 32,
  parameter int SEQ_W  = 8,
  parameter int LVL_W  = 3,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [SEQ_W-1:0]  out_seq;
  logic              out_ready;
  logic              flush_req;
  logic [LVL_W-1:0]  flush_lvl;
  logic [LVL_W-1:0]  occupancy;
  logic [CNT_W-1:0]  kill_cnt;

  modport master (
    output in_valid, in_data, out_ready, flush_req, flush_lvl,
    input  in_ready, out_valid, out_data, out_seq, occupancy, kill_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush_req, flush_lvl,
    output in_ready, out_valid, out_data, out_seq, occupancy, kill_cnt
  );
endinterface

// File: rtl/elastic_pipe_chain.sv
// Stallable, flushable chain of DEPTH pipeline registers with valid/ready
// back-pressure and bubble collapse. Stage 0 is the youngest (entry),
// stage DEPTH-1 the oldest (exit). Each accepted entry carries a wrapping
// sequence tag. Flush kills the youngest min(flush_lvl, DEPTH) stages.
// Ports:
//   CLK  rising-edge clock
//   RST  asynchronous active-high reset
//   bus  elastic_pipe_chain_if.slave (entry/exit handshake, flush, status)
module elastic_pipe_chain #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int SEQ_W  = 8,
  parameter int LVL_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  elastic_pipe_chain_if.slave  bus
);

  logic [DEPTH-1:0]  r_v;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [SEQ_W-1:0]  r_seq  [DEPTH];
  logic [SEQ_W-1:0]  r_seq_next;
  logic [LVL_W-1:0]  r_occ;
  logic [CNT_W-1:0]  r_kill_cnt;

  logic [DEPTH-1:0]  w_mv;
  logic [DEPTH-1:0]  w_kill;
  logic [DEPTH-1:0]  w_gone;
  logic [DEPTH-1:0]  w_ld;
  logic [DEPTH-1:0]  w_v_nxt;
  logic [LVL_W-1:0]  w_lvl;
  logic [LVL_W-1:0]  w_kill_n;
  logic [LVL_W-1:0]  w_occ_nxt;
  logic [CNT_W:0]    w_kill_sum;
  logic              w_in_ready;
  logic              w_acc;

  always_comb begin
    // Move chain resolved from the exit backwards.
    w_mv            = '0;
    w_mv[DEPTH-1]   = r_v[DEPTH-1] & bus.out_ready;
    for (int unsigned j = 1; j < DEPTH; j++) begin
      w_mv[DEPTH-1-j] = r_v[DEPTH-1-j] & (~r_v[DEPTH-j] | w_mv[DEPTH-j]);
    end

    w_in_ready = (~r_v[0] | w_mv[0]) & ~bus.flush_req;
    w_acc      = bus.in_valid & w_in_ready;

    w_lvl = '0;
    if (bus.flush_req) begin
      w_lvl = (bus.flush_lvl > LVL_W'(DEPTH)) ? LVL_W'(DEPTH) : bus.flush_lvl;
    end

    w_kill = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_kill[i] = (LVL_W'(i) < w_lvl);
    end

    w_ld       = '0;
    w_ld[0]    = w_acc;
    w_v_nxt    = '0;
    w_v_nxt[0] = ~w_kill[0] & (w_acc | (r_v[0] & ~w_mv[0]));
    for (int unsigned i = 1; i < DEPTH; i++) begin
      // An entry leaving a killed stage is discarded rather than loaded.
      w_ld[i]    = w_mv[i-1] & ~w_kill[i-1] & ~w_kill[i];
      w_v_nxt[i] = ~w_kill[i] & (w_ld[i] | (r_v[i] & ~w_mv[i]));
    end

    // An exit handshake in a full-depth flush is a delivery, not a kill.
    w_gone          = r_v & w_kill;
    w_gone[DEPTH-1] = w_gone[DEPTH-1] & ~w_mv[DEPTH-1];

    w_kill_n  = '0;
    w_occ_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_kill_n  = w_kill_n  + LVL_W'(w_gone[i]);
      w_occ_nxt = w_occ_nxt + LVL_W'(w_v_nxt[i]);
    end

    w_kill_sum = {1'b0, r_kill_cnt} + (CNT_W+1)'(w_kill_n);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_v        <= '0;
      r_seq_next <= '0;
      r_occ      <= '0;
      r_kill_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_seq[i]  <= '0;
      end
    end else begin
      r_v   <= w_v_nxt;
      r_occ <= w_occ_nxt;
      r_kill_cnt <= w_kill_sum[CNT_W] ? '1 : w_kill_sum[CNT_W-1:0];
      if (w_acc) begin
        r_data[0]  <= bus.in_data;
        r_seq[0]   <= r_seq_next;
        r_seq_next <= r_seq_next + 1'b1;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (w_ld[i]) begin
          r_data[i] <= r_data[i-1];
          r_seq[i]  <= r_seq[i-1];
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_v[DEPTH-1];
  assign bus.out_data  = r_data[DEPTH-1];
  assign bus.out_seq   = r_seq[DEPTH-1];
  assign bus.occupancy = r_occ;
  assign bus.kill_cnt  = r_kill_cnt;

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Bench for elastic_pipe_chain: directed scenarios plus a randomized run
// against a positional queue model (each in-flight entry knows its stage).
module tb_elastic_pipe_chain;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  elastic_pipe_chain_if #(.DATA_W(32), .SEQ_W(8), .LVL_W(3), .CNT_W(16)) bus ();
  elastic_pipe_chain_if #(.DATA_W(32), .SEQ_W(2), .LVL_W(3), .CNT_W(16)) bus2 ();

  elastic_pipe_chain #(.DATA_W(32), .DEPTH(DEPTH), .SEQ_W(8), .LVL_W(3), .CNT_W(16))
    dut (.CLK(clk), .RST(rst), .bus(bus));
  elastic_pipe_chain #(.DATA_W(32), .DEPTH(DEPTH), .SEQ_W(2), .LVL_W(3), .CNT_W(16))
    dut2 (.CLK(clk), .RST(rst), .bus(bus2));

  typedef struct {
    logic [31:0] d;
    logic [7:0]  s;
    int          pos;
  } ent_t;

  ent_t        q[$];
  logic [7:0]  m_seq;
  int          m_kill;
  logic        d_iv, d_or, d_fr;
  logic [31:0] d_id;
  logic [2:0]  d_fl;
  int          total = 0;
  int          bad   = 0;

  // Entry can be taken if, after every older entry advances as far as it
  // can, position 0 is free.
  function automatic bit m_ready();
    int lim = DEPTH;
    if (d_fr) return 1'b0;
    foreach (q[i]) begin
      if (i == 0 && q[i].pos == DEPTH-1 && d_or) continue;
      lim = (q[i].pos + 1 < lim - 1) ? q[i].pos + 1 : lim - 1;
    end
    return lim > 0;
  endfunction

  task automatic drive(input logic iv, input logic [31:0] id, input logic ordy,
                       input logic fr, input logic [2:0] fl);
    d_iv = iv; d_id = id; d_or = ordy; d_fr = fr; d_fl = fl;
    bus.in_valid = iv; bus.in_data = id; bus.out_ready = ordy;
    bus.flush_req = fr; bus.flush_lvl = fl;
    #1;
  endtask

  task automatic tick();
    bit rdy;
    int L, k, lim;
    rdy = m_ready();
    L = d_fr ? ((int'(d_fl) > DEPTH) ? DEPTH : int'(d_fl)) : 0;
    if (q.size() > 0 && q[0].pos == DEPTH-1 && d_or) void'(q.pop_front());
    k = 0;
    while (q.size() > 0 && q[q.size()-1].pos < L) begin
      void'(q.pop_back());
      k++;
    end
    lim = DEPTH;
    foreach (q[i]) begin
      q[i].pos = (q[i].pos + 1 < lim - 1) ? q[i].pos + 1 : lim - 1;
      lim = q[i].pos;
    end
    if (d_iv && rdy) begin
      q.push_back('{d: d_id, s: m_seq, pos: 0});
      m_seq++;
    end
    m_kill = (m_kill + k > 65535) ? 65535 : m_kill + k;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_seq  = '0;
    m_kill = 0;
  endtask

  task automatic fill4(input logic [31:0] base);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, base + 32'(k), 1'b0, 1'b0, '0);
      tick();
    end
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    #2;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%0h exp=0", bus.out_data); end
    total++; if (bus.out_seq !== 8'h0) begin bad++; $display("FAIL reset_out_seq got=%0h exp=0", bus.out_seq); end
    total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", bus.occupancy); end
    total++; if (bus.kill_cnt !== 16'd0) begin bad++; $display("FAIL reset_kill_cnt got=%0d exp=0", bus.kill_cnt); end
    do_reset();
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h11 * 32'(k+1), 1'b1, 1'b0, '0);
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready k=%0d got=%0b exp=1", k, bus.in_ready); end
      tick();
      if (k < 3) begin
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stream_latency k=%0d got=%0b exp=0", k, bus.out_valid); end
      end else begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h11 * 32'(k-2) || bus.out_seq !== 8'(k-3)) begin
          bad++;
          $display("FAIL stream_out k=%0d got=%0b/%0h/%0d exp=1/%0h/%0d", k, bus.out_valid, bus.out_data, bus.out_seq, 32'h11 * 32'(k-2), k-3);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fill4(32'hA0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'hEE, 1'b0, 1'b0, '0);
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b exp=0", bus.in_ready); end
      tick();
      total++;
      if (bus.occupancy !== 3'd4 || bus.out_data !== 32'hA0 || bus.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold got=%0d/%0h/%0b exp=4/a0/1", bus.occupancy, bus.out_data, bus.out_valid);
      end
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b1, 1'b0, '0);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA0 + 32'(k) || bus.out_seq !== 8'(k)) begin
        bad++;
        $display("FAIL bp_drain k=%0d got=%0b/%0h/%0d exp=1/%0h/%0d", k, bus.out_valid, bus.out_data, bus.out_seq, 32'hA0 + 32'(k), k);
      end
      tick();
    end
    total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL bp_empty got=%0d exp=0", bus.occupancy); end
  endtask

  task automatic test_bubble();
    do_reset();
    drive(1'b1, 32'hB1, 1'b0, 1'b0, '0); tick();
    drive(1'b0, '0,     1'b0, 1'b0, '0); tick();
    drive(1'b1, 32'hB2, 1'b0, 1'b0, '0); tick();
    drive(1'b0, '0,     1'b0, 1'b0, '0);
    for (int k = 0; k < 4; k++) tick();
    total++;
    if (bus.occupancy !== 3'd2 || bus.out_data !== 32'hB1 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bubble_state got=%0d/%0h/%0b exp=2/b1/1", bus.occupancy, bus.out_data, bus.in_ready);
    end
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    tick();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hB2 || bus.out_seq !== 8'd1) begin
      bad++;
      $display("FAIL bubble_adjacent got=%0b/%0h/%0d exp=1/b2/1", bus.out_valid, bus.out_data, bus.out_seq);
    end
  endtask

  task automatic test_flush_partial();
    int n;
    do_reset();
    fill4(32'hC0);
    drive(1'b1, 32'hDD, 1'b0, 1'b1, 3'd2);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fp_in_ready got=%0b exp=0", bus.in_ready); end
    tick();
    total++;
    if (bus.occupancy !== 3'd2 || bus.kill_cnt !== 16'd2 || bus.out_seq !== 8'd0) begin
      bad++;
      $display("FAIL fp_after got=%0d/%0d/%0d exp=2/2/0", bus.occupancy, bus.kill_cnt, bus.out_seq);
    end
    drive(1'b1, 32'hC4, 1'b1, 1'b0, '0); tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    total++; if (bus.out_seq !== 8'd1) begin bad++; $display("FAIL fp_survivor got=%0d exp=1", bus.out_seq); end
    tick();
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 8) begin tick(); n++; end
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_seq !== 8'd4 || bus.out_data !== 32'hC4) begin
      bad++;
      $display("FAIL fp_next_seq got=%0b/%0d/%0h exp=1/4/c4", bus.out_valid, bus.out_seq, bus.out_data);
    end
  endtask

  task automatic test_flush_all();
    do_reset();
    fill4(32'hF0);
    drive(1'b0, '0, 1'b1, 1'b1, 3'd7);
    total++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_seq !== 8'd0) begin
      bad++;
      $display("FAIL fa_cycle got=%0b/%0b/%0d exp=0/1/0", bus.in_ready, bus.out_valid, bus.out_seq);
    end
    tick();
    total++;
    if (bus.occupancy !== 3'd0 || bus.out_valid !== 1'b0 || bus.kill_cnt !== 16'd3) begin
      bad++;
      $display("FAIL fa_after got=%0d/%0b/%0d exp=0/0/3", bus.occupancy, bus.out_valid, bus.kill_cnt);
    end
    drive(1'b1, 32'h55, 1'b1, 1'b1, 3'd0);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fa_lvl0_ready got=%0b exp=0", bus.in_ready); end
    tick();
    total++;
    if (bus.occupancy !== 3'd0 || bus.kill_cnt !== 16'd3) begin
      bad++;
      $display("FAIL fa_lvl0_after got=%0d/%0d exp=0/3", bus.occupancy, bus.kill_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    fill4(32'h70);
    drive(1'b0, '0, 1'b0, 1'b1, 3'd1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    total++;
    if (bus.occupancy !== 3'd3 || bus.kill_cnt !== 16'd1) begin
      bad++;
      $display("FAIL ar_pre got=%0d/%0d exp=3/1", bus.occupancy, bus.kill_cnt);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd0 || bus.kill_cnt !== 16'd0) begin
      bad++;
      $display("FAIL ar_now got=%0b/%0d/%0d exp=0/0/0", bus.out_valid, bus.occupancy, bus.kill_cnt);
    end
    #2 rst = 1'b0;
    q.delete(); m_seq = '0; m_kill = 0;
    @(posedge clk); #1;
    drive(1'b1, 32'h77, 1'b1, 1'b0, '0); tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ar_ghost k=%0d got=%0b exp=0", k, bus.out_valid); end
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_seq !== 8'd0 || bus.out_data !== 32'h77) begin
      bad++;
      $display("FAIL ar_first got=%0b/%0d/%0h exp=1/0/77", bus.out_valid, bus.out_seq, bus.out_data);
    end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int got  = 0;
    do_reset();
    for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
      bus2.in_valid  = (sent < 6);
      bus2.in_data   = 32'(sent);
      bus2.out_ready = 1'b1;
      #1;
      if (bus2.out_valid === 1'b1) begin
        total++;
        if (bus2.out_seq !== 2'(got % 4) || bus2.out_data !== 32'(got)) begin
          bad++;
          $display("FAIL wrap_seq n=%0d got=%0d/%0h exp=%0d/%0h", got, bus2.out_seq, bus2.out_data, got % 4, got);
        end
        got++;
      end
      if (bus2.in_valid && bus2.in_ready === 1'b1) sent++;
      @(posedge clk); #1;
    end
    bus2.in_valid = 1'b0;
    total++; if (got != 6) begin bad++; $display("FAIL wrap_count got=%0d exp=6", got); end
  endtask

  task automatic test_random();
    bit ev;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 11) == 0), 3'($urandom_range(0, 7)));
      total++; if (bus.in_ready !== m_ready()) begin bad++; $display("FAIL rnd_in_ready c=%0d got=%0b exp=%0b", c, bus.in_ready, m_ready()); end
      tick();
      ev = (q.size() > 0) && (q[0].pos == DEPTH-1);
      total++; if (bus.out_valid !== ev) begin bad++; $display("FAIL rnd_out_valid c=%0d got=%0b exp=%0b", c, bus.out_valid, ev); end
      if (ev) begin
        total++;
        if (bus.out_data !== q[0].d || bus.out_seq !== q[0].s) begin
          bad++;
          $display("FAIL rnd_out c=%0d got=%0h/%0d exp=%0h/%0d", c, bus.out_data, bus.out_seq, q[0].d, q[0].s);
        end
      end
      total++; if (bus.occupancy !== 3'(q.size())) begin bad++; $display("FAIL rnd_occ c=%0d got=%0d exp=%0d", c, bus.occupancy, q.size()); end
      total++; if (bus.kill_cnt !== 16'(m_kill)) begin bad++; $display("FAIL rnd_kill c=%0d got=%0d exp=%0d", c, bus.kill_cnt, m_kill); end
    end
  endtask

  initial begin
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0;
    bus2.flush_req = 1'b0; bus2.flush_lvl = '0;
    q.delete(); m_seq = '0; m_kill = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush_partial();
    test_flush_all();
    test_async_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
